// File: rtl/min_int_serial.sv
// Bit-serial signed minimum of two MSB-first operand streams, 1-cycle latency.
// Define MIN_SERIAL_SEL_OUT_EN to expose out_sel (final operand choice per word).
module min_int_serial #(
  parameter int WIDTH = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_valid,
  input  logic in_a,
  input  logic in_b,
  output logic out_valid,
  output logic out_y,
  output logic out_last
`ifdef MIN_SERIAL_SEL_OUT_EN
  ,
  output logic out_sel
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;
  logic          decided;
  logic          pick_b;

  logic first;
  logic last;
  logic acc;
  logic dec_n;
  logic pb_n;
  logic y;

  // Per-bit decision: sign bit restarts the comparison, later bits refine it
  always_comb begin
    first = (cnt == '0);
    last  = (cnt == CNT_MAX);
    acc   = in_valid & ~clr;
    dec_n = decided;
    pb_n  = pick_b;
    y     = in_a;
    unique case (1'b1)
      first: begin
        if (in_a != in_b) begin
          dec_n = 1'b1;
          pb_n  = in_b;
          y     = 1'b1;
        end else begin
          dec_n = 1'b0;
          pb_n  = 1'b0;
          y     = in_a;
        end
      end
      (~first & ~decided): begin
        if (in_a != in_b) begin
          dec_n = 1'b1;
          pb_n  = in_a;
          y     = 1'b0;
        end else begin
          y = in_a;
        end
      end
      (~first & decided): begin
        y = pick_b ? in_b : in_a;
      end
      default: y = in_a;
    endcase
  end

  // Word framing counter; clr aborts the current word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  // Decision state held across the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decided <= 1'b0;
      pick_b  <= 1'b0;
    end else if (clr) begin
      decided <= 1'b0;
    end else if (in_valid) begin
      decided <= dec_n;
      pick_b  <= pb_n;
    end
  end

  // Registered outputs; out_y holds across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= acc;
      out_last  <= acc & last;
      if (acc) out_y <= y;
    end
  end

`ifdef MIN_SERIAL_SEL_OUT_EN
  // Final pick of the word, published with out_last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sel <= 1'b0;
    end else if (acc & last) begin
      out_sel <= pb_n;
    end
  end
`endif

endmodule
